// File: rtl/i2c_master_pkg.sv
// Shared I2C master definitions: state_master encodings, default bit timing
// and counter widths used by scl_generate and sda_generate.
package i2c_master_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_READY     = 4'd1,
    ST_SEND_ADDR = 4'd2,
    ST_CHK_ACK_A = 4'd3,
    ST_WR_DATA   = 4'd4,
    ST_CHK_ACK_D = 4'd5,
    ST_RD_DATA   = 4'd6,
    ST_SEND_ACK  = 4'd7,
    ST_STOP      = 4'd8
  } state_master_e;

  localparam int ADDR_LEN_DEF        = 7;
  localparam int DATA_LEN_DEF        = 8;
  localparam int SETUP_SDA_START_DEF = 2;
  localparam int T_HD_STA_DEF        = 2;
  localparam int T_LOW_DEF           = 6;
  localparam int T_HIGH_DEF          = 4;
  localparam int STRETCH_MAX_DEF     = 64;

  localparam int CTRL_W = 7;
  localparam int CNT_W  = 4;

  // States in which the master is clocking bit periods on SCL.
  function automatic logic is_bit_state(input logic [3:0] st);
    return (st >= ST_SEND_ADDR) && (st <= ST_STOP);
  endfunction

  // States whose bit periods advance the bit counter.
  function automatic logic is_shift_state(input logic [3:0] st);
    return (st == ST_SEND_ADDR) || (st == ST_WR_DATA) || (st == ST_RD_DATA);
  endfunction

endpackage

// File: rtl/scl_stretch_mon.sv
// Clock-stretch monitor: synchronises the SCL pad, flags a slave holding SCL
// low during the high phase, and times out a stretch into a sticky bus error.
module scl_stretch_mon
  import i2c_master_pkg::*;
#(
  parameter int T_LOW       = T_LOW_DEF,
  parameter int STRETCH_MAX = STRETCH_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              scl_in,
  input  logic              active,
  input  logic              clr_err,
  input  logic [CTRL_W-1:0] count_ctrl,
  input  logic              scl,
  output logic              stall,
  output logic              bus_error
);

  localparam int TMR_W = $clog2(STRETCH_MAX + 1);
  localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(STRETCH_MAX - 1);
  localparam logic [CTRL_W-1:0] CTRL_LOW = CTRL_W'(T_LOW);

  logic             sync1_q, scl_s_q;
  logic             release_q, release_d;
  logic             bus_error_q, bus_error_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             hold_seen;
  logic             tmr_tc;

  assign hold_seen = active && (count_ctrl >= CTRL_LOW) && scl && !scl_s_q;
  assign stall     = hold_seen && !release_q;
  assign tmr_tc    = (tmr_q == '0);
  assign bus_error = bus_error_q;

  always_comb begin
    tmr_d       = TMR_LOAD;
    release_d   = release_q;
    bus_error_d = bus_error_q;
    if (stall) begin
      if (tmr_tc) begin
        release_d   = 1'b1;
        bus_error_d = 1'b1;
      end else begin
        tmr_d = tmr_q - TMR_W'(1);
      end
    end
    // A timed-out stretch is ignored only until the next low phase begins.
    if (!active || (count_ctrl < CTRL_LOW)) release_d = 1'b0;
    if (clr_err) bus_error_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 1'b1;
      scl_s_q     <= 1'b1;
      release_q   <= 1'b0;
      bus_error_q <= 1'b0;
      tmr_q       <= TMR_LOAD;
    end else begin
      sync1_q     <= scl_in;
      scl_s_q     <= sync1_q;
      release_q   <= release_d;
      bus_error_q <= bus_error_d;
      tmr_q       <= tmr_d;
    end
  end

endmodule

// File: rtl/scl_generate.sv
// I2C master bit-timing engine: SCL generation, intra-bit and bit counters,
// and the single-clk phase events that pace the SDA/FSM block.
module scl_generate
  import i2c_master_pkg::*;
#(
  parameter int ADDR_LEN        = ADDR_LEN_DEF,
  parameter int DATA_LEN        = DATA_LEN_DEF,
  parameter int SETUP_SDA_START = SETUP_SDA_START_DEF,
  parameter int T_HD_STA        = T_HD_STA_DEF,
  parameter int T_LOW           = T_LOW_DEF,
  parameter int T_HIGH          = T_HIGH_DEF,
  parameter int STRETCH_MAX     = STRETCH_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        state_master,
  input  logic              rst_count,
  input  logic              rst_count_2,
  input  logic              scl_in,
  output logic              scl,
  output logic              scl_oe,
  output logic [CTRL_W-1:0] count_ctrl,
  output logic [CNT_W-1:0]  count,
  output logic              wait_for_sync,
  output logic              add_sent,
  output logic              data_sent,
  output logic              data_received,
  output logic              bus_error
);

  localparam logic [CTRL_W-1:0] CTRL_LAST     = CTRL_W'(T_LOW + T_HIGH - 1);
  localparam logic [CTRL_W-1:0] CTRL_LOW      = CTRL_W'(T_LOW);
  localparam logic [CTRL_W-1:0] CTRL_SYNC     = CTRL_W'(SETUP_SDA_START + T_HD_STA - 1);
  localparam logic [CTRL_W-1:0] CTRL_MAX      = '1;
  localparam logic [CNT_W-1:0]  CNT_ADDR_LAST = CNT_W'(ADDR_LEN);
  localparam logic [CNT_W-1:0]  CNT_DATA_LAST = CNT_W'(DATA_LEN - 1);

  logic [CTRL_W-1:0] count_ctrl_q, count_ctrl_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              scl_q, scl_d;
  logic              in_idle, in_ready, in_bit, in_shift;
  logic              stall, last_clk, wrap;

  assign in_idle  = (state_master == ST_IDLE);
  assign in_ready = (state_master == ST_READY);
  assign in_bit   = is_bit_state(state_master);
  assign in_shift = is_shift_state(state_master);

  scl_stretch_mon #(
    .T_LOW       (T_LOW),
    .STRETCH_MAX (STRETCH_MAX)
  ) u_stretch (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_in     (scl_in),
    .active     (in_bit),
    .clr_err    (in_idle),
    .count_ctrl (count_ctrl_q),
    .scl        (scl_q),
    .stall      (stall),
    .bus_error  (bus_error)
  );

  assign last_clk = (count_ctrl_q == CTRL_LAST) && !stall;
  assign wrap     = in_bit && last_clk;

  always_comb begin
    count_ctrl_d = count_ctrl_q;
    if (rst_count) begin
      count_ctrl_d = '0;
    end else if (in_bit) begin
      if (!stall) count_ctrl_d = wrap ? '0 : count_ctrl_q + CTRL_W'(1);
    end else if (in_ready) begin
      if (count_ctrl_q != CTRL_MAX) count_ctrl_d = count_ctrl_q + CTRL_W'(1);
    end else begin
      count_ctrl_d = '0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (rst_count_2)           count_d = '0;
    else if (wrap && in_shift) count_d = count_q + CNT_W'(1);
  end

  // scl is derived from the next count_ctrl so the two registers stay aligned;
  // a held count_ctrl during a stretch therefore also holds scl.
  always_comb begin
    scl_d = 1'b1;
    if (in_bit) scl_d = (count_ctrl_d >= CTRL_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_ctrl_q <= '0;
      count_q      <= '0;
      scl_q        <= 1'b1;
    end else begin
      count_ctrl_q <= count_ctrl_d;
      count_q      <= count_d;
      scl_q        <= scl_d;
    end
  end

  assign scl        = scl_q;
  assign scl_oe     = ~scl_q;
  assign count_ctrl = count_ctrl_q;
  assign count      = count_q;

  assign wait_for_sync = in_ready && (count_ctrl_q == CTRL_SYNC);
  assign add_sent      = (state_master == ST_SEND_ADDR) && (count_q == CNT_ADDR_LAST) && last_clk;
  assign data_sent     = (state_master == ST_WR_DATA)   && (count_q == CNT_DATA_LAST) && last_clk;
  assign data_received = (state_master == ST_RD_DATA)   && (count_q == CNT_DATA_LAST) && last_clk;

endmodule
